// File: rtl/alu_instr_sequencer.sv
`timescale 1ns/1ps
// Hardwired fetch/decode/execute control sequencer for the phase-1 ALU datapath.
// Latency: 6 + FETCH_WAIT cycles per instruction (T0..T5); strobes decode combinationally from state.
// Backpressure: none; slow memory is absorbed by holding T1 for FETCH_WAIT extra cycles.
module alu_instr_sequencer #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir_data,
    output logic        pc_out,
    output logic        pc_increment,
    output logic        pc_enable,
    output logic        mar_enable,
    output logic        read,
    output logic        mdr_enable,
    output logic        mdr_out,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        z_enable,
    output logic        zlo_out,
    output logic [15:0] r_out,
    output logic [15:0] r_enable,
    output logic [4:0]  op_code,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_FAULT = 4'd7
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(FETCH_WAIT);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_binary, is_unary;
    logic       unused_ir_bits;

    assign opcode = ir_data[31:27];
    assign ra     = ir_data[26:23];
    assign rb     = ir_data[22:19];
    assign rc     = ir_data[18:15];

    // Low IR bits carry no meaning for ALU-format instructions.
    assign unused_ir_bits = ^ir_data[14:0];

    // Classify the IR opcode as binary, unary or neither (illegal).
    always_comb begin
        is_binary = 1'b0;
        is_unary  = 1'b0;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: is_binary = 1'b1;
            5'b10001, 5'b10010:                     is_unary  = 1'b1;
            default: ;
        endcase
    end

    // Next-state and fetch-wait counter; run only matters in IDLE and T5.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                wait_d  = WAIT_INIT;
            end
            S_T1: begin
                if (wait_q != 3'd0) wait_d  = wait_q - 3'd1;
                else                state_d = S_T2;
            end
            S_T2:    state_d = S_T3;
            S_T3:    state_d = (is_binary || is_unary) ? S_T4 : S_FAULT;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = run ? S_T0 : S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers; clr forces IDLE asynchronously.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Strobe decode from the current state and IR; at most one bus driver per state.
    always_comb begin
        pc_out       = 1'b0;
        pc_increment = 1'b0;
        mar_enable   = 1'b0;
        read         = 1'b0;
        mdr_enable   = 1'b0;
        mdr_out      = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        zlo_out      = 1'b0;
        r_out        = 16'h0000;
        r_enable     = 16'h0000;
        op_code      = 5'b00000;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
            end
            S_T1: begin
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: begin
                // Unary ops leave T3 as a bubble so both formats share T4/T5.
                if (is_binary) begin
                    r_out    = 16'h0001 << rb;
                    y_enable = 1'b1;
                end
            end
            S_T4: begin
                r_out    = 16'h0001 << (is_binary ? rc : rb);
                z_enable = 1'b1;
                op_code  = opcode;
            end
            S_T5: begin
                zlo_out    = 1'b1;
                r_enable   = 16'h0001 << ra;
                instr_done = 1'b1;
            end
            S_FAULT: illegal = 1'b1;
            default: ;
        endcase
    end

    // No branch support in this block, so the PC is never loaded from the bus.
    assign pc_enable = 1'b0;
    assign state_dbg = state_q;

endmodule
